serial_slice_addsub: RTL and testbench
======================================

// Module: serial_slice_addsub
//
// PURPOSE
//  Multi-cycle WIDTH-bit adder/subtractor that reuses one SLICE-bit ripple slice,
//  processing one slice per clock from LSB to MSB with a registered carry.
//  It is the sequential, handshaked counterpart of the combinational ripple adders.
//  It trades latency for area in the 32-bit datapath.
//  Operands enter on a valid/ready request port; results leave on a valid/ready response port.
//
// PARAMETERS
//  WIDTH   32   operand/result width; must be an integer multiple of SLICE
//  SLICE    8   bits processed per cycle
//  NSLICE  WIDTH/SLICE (localparam)   number of RUN cycles per operation
//
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      request operands valid
//  in_ready   out  1      block can accept a request (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+cin   1: a-b-cin
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      final carry out (for sub: 1 = no borrow)
//  overflow   out  1      two's-complement signed overflow
//
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, slice index=0; in_ready=1 on the first cycle after reset.
//    out_valid=0, sum=0, cout=0, overflow=0. Reset overrides any in-flight operation,
//    which is discarded without a response.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid&&in_ready, latch a, b and sub; go to RUN with idx=0.
//    - Latch b_eff = sub ? ~b : b and carry register c = sub ? ~cin : cin.
//  - RUN:
//    - Each cycle: {c_next, sum[idx*SLICE +: SLICE]} = a_slice + b_eff_slice + c.
//    - Register c <= c_next, then idx++.
//    - After the slice with idx==NSLICE-1, go to DONE.
//    - On that final slice, capture cout=c_next and overflow = carry into MSB ^ c_next.
//    - in_ready=0 throughout.
//  - DONE:
//    - out_valid=1; sum/cout/overflow stable.
//    - On out_ready, go to IDLE; out_valid drops the next cycle.
//    - No request is accepted in the same cycle as out_ready (in_ready=0 in DONE).
//  - Latency:
//    - Request accepted at edge T -> out_valid high in the cycle after edge T+NSLICE.
//    - Issue interval, with out_ready held high: NSLICE+2 cycles.
//  - sum, cout and overflow change only while in RUN; they hold their last value in IDLE.
//  - Inputs a, b, cin and sub are ignored outside IDLE handshake cycles.
//  - Wrap-around: results are modulo 2^WIDTH; the carry/borrow is reported only via cout.
//  - out_ready held low in DONE: the block stalls indefinitely with outputs frozen.
//
// STRUCTURE
//  - Shared package:
//    - state enum {IDLE, RUN, DONE}
//    - default WIDTH/SLICE constants
//  - Sub-module slice_adder #(SLICE):
//    - Pure combinational SLICE-bit ripple of full adders.
//    - Outputs: sum, cout, and c_msb (carry into the top bit) for overflow.
//  - Top level: FSM, idx counter ($clog2(NSLICE) bits), operand/result registers, carry flop.
//
// TESTING
//  1. After reset: a=0, b=0, cin=0, sub=0 -> sum=00000000, cout=0, ovf=0;
//     out_valid exactly NSLICE+1 cycles after accept.
//  2. a=FFFFFFFF, b=FFFFFFFF, cin=1, sub=0 -> sum=FFFFFFFF, cout=1, ovf=0.
//  3. a=AAAAAAAA, b=55555555, cin=0, sub=0 -> sum=FFFFFFFF, cout=0.
//     Then a=7FFFFFFF, b=00000001 -> sum=80000000, ovf=1.
//  4. Subtract, cin=0 (no borrow-in):
//     - a=00000005, b=00000007, sub=1 -> sum=FFFFFFFE, cout=0, ovf=0.
//     - a=80000000, b=00000001, sub=1 -> sum=7FFFFFFF, cout=1, ovf=1.
//  5. Backpressure: hold out_ready=0 for 10 cycles in DONE.
//     -> out_valid, sum and cout stay constant; in_ready stays 0.
//     Release: out_valid drops the next cycle, and the next request is accepted.
//  6. Reset asserted on the second RUN cycle.
//     -> Next cycle: IDLE, in_ready=1, out_valid=0, sum=0.
//     No stale response appears; a fresh request completes correctly.

Source files
------------

// File: rtl/serial_slice_addsub_pkg.sv
// Shared types and default sizes for the slice-serial adder/subtractor.
package serial_slice_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

endpackage

// File: rtl/serial_slice_addsub_slice.sv
// Combinational SLICE-bit ripple of full adders; c_msb is the carry into the top
// bit, used with cout to derive two's-complement overflow.
module slice_adder #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout  = carry[SLICE];
  assign c_msb = carry[SLICE-1];

endmodule

// File: rtl/serial_slice_addsub.sv
// WIDTH-bit add/sub, one SLICE per clock LSB first; result valid NSLICE cycles after
// accept and held in DONE until out_ready; in_ready only in IDLE.
module serial_slice_addsub
  import serial_slice_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SLICE-1:0] s_sum;
  logic             s_cout;
  logic             s_cmsb;

  slice_adder #(.SLICE(SLICE)) u_slice (
    .a     (a_q[idx_q*SLICE +: SLICE]),
    .b     (b_q[idx_q*SLICE +: SLICE]),
    .cin   (c_q),
    .sum   (s_sum),
    .cout  (s_cout),
    .c_msb (s_cmsb)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          // Subtraction runs as a + ~b + ~borrow_in on the same adder.
          a_d        = a;
          b_d        = sub ? ~b : b;
          c_d        = sub ? ~cin : cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE +: SLICE] = s_sum;
        c_d   = s_cout;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDXW'(NSLICE - 1)) begin
          cout_d      = s_cout;
          ovf_d       = s_cmsb ^ s_cout;
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        idx_d       = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_slice_addsub.sv
// Scoreboard bench for serial_slice_addsub: directed corner operands, backpressure,
// mid-operation reset and a short random run.
module tb_serial_slice_addsub;

  localparam int W = 32;
  localparam int S = 8;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         sub_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         ovf_o;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  serial_slice_addsub #(.WIDTH(W), .SLICE(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .cin       (cin_i),
    .sub       (sub_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum_o),
    .cout      (cout_o),
    .overflow  (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W-1:0] be;
    logic         c0;
    logic [W:0]   r;
    exp_t         e;
    be     = sub ? ~b : b;
    c0     = sub ? ~cin : cin;
    r      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c0};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Accept one request, then collect and score its response after `stall` held cycles.
  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic cin, input logic sub, input int stall);
    int   lat;
    exp_t e;
    wait_ready(tag);
    in_valid = 1'b1;
    a_i      = a;
    b_i      = b;
    cin_i    = cin;
    sub_i    = sub;
    sb.push_back(model(a, b, cin, sub));
    tick();
    in_valid = 1'b0;
    a_i      = $urandom;
    b_i      = $urandom;
    cin_i    = 1'($urandom);
    sub_i    = 1'($urandom);
    lat      = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(N + 1));
    if (!out_valid) return;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_sum"}, 64'(sum_o), 64'(e.sum));
    check({tag, "_cout"}, 64'(cout_o), 64'(e.cout));
    check({tag, "_ovf"}, 64'(ovf_o), 64'(e.ovf));
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_sum"}, 64'(sum_o), 64'(e.sum));
      check({tag, "_hold_cout"}, 64'(cout_o), 64'(e.cout));
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    check({tag, "_idle_sum_hold"}, 64'(sum_o), 64'(e.sum));
  endtask

  initial begin
    bit seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    a_i       = '0;
    b_i       = '0;
    cin_i     = 1'b0;
    sub_i     = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum_o), 64'd0);
    check("rst_cout", 64'(cout_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);

    op("zero", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 0);
    op("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    op("alt", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 0);
    op("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
    op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
    op("bp", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 10);
    op("after_bp", 32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 0);

    // Abort an operation on its second RUN cycle.
    wait_ready("abort");
    in_valid = 1'b1;
    a_i      = 32'hDEAD_BEEF;
    b_i      = 32'h1111_1111;
    cin_i    = 1'b0;
    sub_i    = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_sum", 64'(sum_o), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < N + 4; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_stale", 64'(seen), 64'd0);
    op("fresh", 32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      op("rand", $urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
